rr_stream_mux: RTL and testbench



---
 rtl/rr_stream_mux_if.sv | 26 ++
 rtl/rr_stream_mux.sv | 78 +++++++
 tb/tb_rr_stream_mux.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_mux_if.sv
// Valid/ready bundle for rr_stream_mux: N input streams and one output stream.
// The slave modport is the mux side; master is the producers/consumer side.
interface rr_stream_mux_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_sel;
   logic           out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel stream mux, round-robin (MODE 0) or lowest-index priority (MODE 1).
// The winner is captured in a one-entry output register that reloads while draining.
module rr_stream_mux #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = 0
) (
   input  logic           clk,
   input  logic           reset,
   rr_stream_mux_if.slave bus
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [SW-1:0] r_ptr;
   logic [SW-1:0] r_sel;
   logic          r_valid;
   logic [W-1:0]  r_data;

   logic          w_load;
   logic          w_any;
   logic          w_take;
   logic [SW-1:0] w_grant;
   logic [SW-1:0] w_ptr_nxt;
   logic [W-1:0]  w_gdata;

   // Scan from the highest offset down so the nearest requester wins last.
   function automatic logic [SW-1:0] f_grant(
      input logic [N-1:0]  v,
      input logic [SW-1:0] p
   );
      f_grant = '0;
      for (int k = N - 1; k >= 0; k--) begin
         int idx;
         idx = (MODE == 0) ? (int'(p) + k) % N : k;
         if (v[idx]) f_grant = SW'(idx);
      end
   endfunction

   assign w_grant   = f_grant(bus.in_valid, r_ptr);
   assign w_ptr_nxt = (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);

   assign w_load = !r_valid || bus.out_ready;
   assign w_any  = |bus.in_valid;
   assign w_take = w_load && w_any && !reset;

   always_comb begin
      w_gdata = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == SW'(i)) w_gdata = bus.in_data[i*W +: W];
      end
   end

   assign bus.in_ready  = w_take ? (N'(1) << w_grant) : '0;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_sel   = r_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else if (w_take) begin
         r_valid <= 1'b1;
         r_data  <= w_gdata;
         r_sel   <= w_grant;
         if (MODE == 0) r_ptr <= w_ptr_nxt;
      end else if (r_valid && bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   a_ready_onehot: assert property (
      @(posedge clk) disable iff (reset) $onehot0(bus.in_ready)
   );

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a round-robin and a fixed-priority instance
// share stimulus and are checked against a queue-free reference model.
module tb_rr_stream_mux;
   logic        clk;
   logic        rst;
   logic [3:0]  v_in;
   logic [31:0] d_in;
   logic        r_in;

   int n_tests = 0;
   int n_fail  = 0;

   logic       m_valid [2];
   logic [7:0] m_data  [2];
   int         m_sel   [2];
   int         m_ptr   [2];

   rr_stream_mux_if #(.N(4), .W(8)) b0 ();
   rr_stream_mux_if #(.N(4), .W(8)) b1 ();

   assign b0.in_valid  = v_in;
   assign b0.in_data   = d_in;
   assign b0.out_ready = r_in;
   assign b1.in_valid  = v_in;
   assign b1.in_data   = d_in;
   assign b1.out_ready = r_in;

   rr_stream_mux #(.N(4), .W(8), .MODE(0)) u_rr (
      .clk   (clk),
      .reset (rst),
      .bus   (b0.slave)
   );

   rr_stream_mux #(.N(4), .W(8), .MODE(1)) u_fp (
      .clk   (clk),
      .reset (rst),
      .bus   (b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Spec rule: first valid channel scanning from ptr (mode 0) or from 0.
   function automatic int m_grant(int mode, logic [3:0] v, int p);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (mode == 1) ? k : (p + k) % 4;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(int b);
      int g;
      g = m_grant(b, v_in, m_ptr[b]);
      if (rst || (m_valid[b] && !r_in) || g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   task automatic tick();
      for (int b = 0; b < 2; b++) begin
         int   g;
         logic ld;
         ld = !m_valid[b] || r_in;
         g  = m_grant(b, v_in, m_ptr[b]);
         if (rst) begin
            m_valid[b] = 1'b0;
            m_data[b]  = 8'h00;
            m_sel[b]   = 0;
            m_ptr[b]   = 0;
         end else if (ld && g >= 0) begin
            m_valid[b] = 1'b1;
            m_data[b]  = d_in[g*8 +: 8];
            m_sel[b]   = g;
            if (b == 0) m_ptr[b] = (g + 1) % 4;
         end else if (m_valid[b] && r_in) begin
            m_valid[b] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v_in = 4'h0;
      r_in = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      v_in = 4'b1111;
      d_in = 32'h1312_1110;
      r_in = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if (b0.in_ready !== 4'b0000 || b1.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready cyc %0d: got %b/%b want 0000",
                     c, b0.in_ready, b1.in_ready);
         end
         tick();
         n_tests++;
         if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h00 ||
             b0.out_sel !== 2'd0 || b1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out cyc %0d: got v=%b d=%h s=%0d want 0,00,0",
                     c, b0.out_valid, b0.out_data, b0.out_sel);
         end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (b0.in_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL first_grant_ready: got %b want 0001", b0.in_ready);
      end
      tick();
      n_tests++;
      if (b0.out_valid !== 1'b1 || b0.out_sel !== 2'd0 ||
          b0.out_data !== 8'h10) begin
         n_fail++;
         $display("FAIL first_grant: got v=%b s=%0d d=%h want 1,0,10",
                  b0.out_valid, b0.out_sel, b0.out_data);
      end
   endtask

   task automatic test_single();
      r_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v_in = 4'(1 << i);
         d_in = $urandom();
         d_in[i*8 +: 8] = 8'hA0 + 8'(i);
         #1;
         n_tests++;
         if (b0.in_ready !== 4'(1 << i)) begin
            n_fail++;
            $display("FAIL single_ready ch%0d: got %b want %b",
                     i, b0.in_ready, 4'(1 << i));
         end
         tick();
         n_tests++;
         if (b0.out_valid !== 1'b1 || b0.out_data !== 8'hA0 + 8'(i) ||
             b0.out_sel !== 2'(i)) begin
            n_fail++;
            $display("FAIL single_out ch%0d: got v=%b d=%h s=%0d want 1,%h,%0d",
                     i, b0.out_valid, b0.out_data, b0.out_sel, 8'hA0 + 8'(i), i);
         end
      end
   endtask

   task automatic test_rotation();
      do_reset();
      v_in = 4'b1111;
      d_in = 32'h1312_1110;
      r_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_tests++;
         if (b0.in_ready !== 4'(1 << (k % 4))) begin
            n_fail++;
            $display("FAIL rot_ready k%0d: got %b want %b",
                     k, b0.in_ready, 4'(1 << (k % 4)));
         end
         tick();
         n_tests++;
         if (b0.out_valid !== 1'b1 || b0.out_sel !== 2'(k % 4) ||
             b0.out_data !== 8'h10 + 8'(k % 4)) begin
            n_fail++;
            $display("FAIL rot_out k%0d: got v=%b s=%0d d=%h want 1,%0d",
                     k, b0.out_valid, b0.out_sel, b0.out_data, k % 4);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      v_in = 4'b0100;
      d_in = 32'h0055_0000;
      r_in = 1'b1;
      tick();
      v_in = 4'b1111;
      d_in = 32'h3355_1100;
      r_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (b0.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready cyc %0d: got %b want 0000", c, b0.in_ready);
         end
         tick();
         n_tests++;
         if (b0.out_valid !== 1'b1 || b0.out_data !== 8'h55 ||
             b0.out_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold cyc %0d: got v=%b d=%h s=%0d want 1,55,2",
                     c, b0.out_valid, b0.out_data, b0.out_sel);
         end
      end
      r_in = 1'b1;
      #1;
      n_tests++;
      if (b0.in_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b want 1000", b0.in_ready);
      end
      tick();
      n_tests++;
      if (b0.out_sel !== 2'd3 || b0.out_data !== 8'h33) begin
         n_fail++;
         $display("FAIL bp_release: got s=%0d d=%h want 3,33",
                  b0.out_sel, b0.out_data);
      end
   endtask

   task automatic test_fixed();
      do_reset();
      v_in = 4'b1010;
      d_in = 32'hC3B2_A190;
      r_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_tests++;
         if (b1.in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL fp_ready cyc %0d: got %b want 0010", c, b1.in_ready);
         end
         tick();
         n_tests++;
         if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'd1 ||
             b1.out_data !== 8'hA1) begin
            n_fail++;
            $display("FAIL fp_out cyc %0d: got v=%b s=%0d d=%h want 1,1,a1",
                     c, b1.out_valid, b1.out_sel, b1.out_data);
         end
      end
      v_in = 4'b1000;
      #1;
      tick();
      n_tests++;
      if (b1.out_sel !== 2'd3 || b1.out_data !== 8'hC3) begin
         n_fail++;
         $display("FAIL fp_drop: got s=%0d d=%h want 3,c3",
                  b1.out_sel, b1.out_data);
      end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      v_in = 4'b0100;
      d_in = 32'h4433_2211;
      r_in = 1'b1;
      tick();
      v_in = 4'b1001;
      for (int c = 0; c < 2; c++) begin
         #1;
         tick();
         n_tests++;
         if (b0.out_sel !== ((c == 0) ? 2'd3 : 2'd0)) begin
            n_fail++;
            $display("FAIL wrap cyc %0d: got s=%0d want %0d",
                     c, b0.out_sel, (c == 0) ? 3 : 0);
         end
      end
      rst  = 1'b1;
      r_in = 1'b0;
      #1;
      n_tests++;
      if (b0.in_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b want 0000", b0.in_ready);
      end
      tick();
      n_tests++;
      if (b0.out_valid !== 1'b0 || b0.out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_out: got v=%b s=%0d want 0,0",
                  b0.out_valid, b0.out_sel);
      end
      rst  = 1'b0;
      r_in = 1'b1;
      v_in = 4'b1111;
      #1;
      n_tests++;
      if (b0.in_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL midrst_ptr: got %b want 0001", b0.in_ready);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom_range(0, 59) == 0);
         v_in = 4'($urandom());
         d_in = $urandom();
         r_in = ($urandom_range(0, 9) < 7);
         #1;
         n_tests++;
         if (b0.in_ready !== m_ready(0) || b1.in_ready !== m_ready(1)) begin
            n_fail++;
            $display("FAIL rnd_ready cyc %0d: got %b/%b want %b/%b",
                     c, b0.in_ready, b1.in_ready, m_ready(0), m_ready(1));
         end
         tick();
         n_tests++;
         if (b0.out_valid !== m_valid[0] || b0.out_data !== m_data[0] ||
             b0.out_sel !== 2'(m_sel[0]) || b1.out_valid !== m_valid[1] ||
             b1.out_data !== m_data[1] || b1.out_sel !== 2'(m_sel[1])) begin
            n_fail++;
            $display("FAIL rnd_out cyc %0d: got %b%h%0d/%b%h%0d want %b%h%0d/%b%h%0d",
                     c, b0.out_valid, b0.out_data, b0.out_sel,
                     b1.out_valid, b1.out_data, b1.out_sel,
                     m_valid[0], m_data[0], m_sel[0],
                     m_valid[1], m_data[1], m_sel[1]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int b = 0; b < 2; b++) begin
         m_valid[b] = 1'b0;
         m_data[b]  = 8'h00;
         m_sel[b]   = 0;
         m_ptr[b]   = 0;
      end
      rst  = 1'b1;
      v_in = 4'h0;
      d_in = 32'h0;
      r_in = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_fixed();
      test_wrap_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
